// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT word registers,
// one-shot or auto-reload operation and a maskable level interrupt.
module timer_counter #(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    logic               en;
    logic [1:0]         mode;
    logic               im;
    logic [COUNT_W-1:0] preset;
    logic [COUNT_W-1:0] count;
    logic               irq_flag;
    logic [1:0]         state;

    logic wr_ctrl;
    logic wr_preset;

    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_preset = we && (addr == A_PRESET);

    // FSM updates come first; the bus writes below are later non-blocking
    // assignments, so a same-edge CTRL write or flag clear overrides the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en       <= 1'b0;
            mode     <= 2'd0;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            state    <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) state <= S_LOAD;
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (count > COUNT_W'(1)) begin
                        count <= count - COUNT_W'(1);
                    end else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= S_INT;
                    end
                end
                default: begin
                    // Only MODE=1 reloads; the reserved encodings behave as one-shot.
                    if (mode == 2'd1) begin
                        irq_flag <= 1'b0;
                        state    <= S_LOAD;
                    end else begin
                        en    <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase

            if (wr_ctrl) begin
                en   <= din[0];
                mode <= din[2:1];
                im   <= din[3];
            end
            if (wr_preset) preset <= din[COUNT_W-1:0];
            if (wr_ctrl || wr_preset) irq_flag <= 1'b0;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            A_CTRL:   dout = {28'd0, im, mode, en};
            A_PRESET: dout = 32'(preset);
            A_COUNT:  dout = 32'(count);
            default:  dout = 32'd0;
        endcase
    end

    assign irq = im & irq_flag;

endmodule
